// File: rtl/net_tx_arb_if.sv
// AXI-Stream bundle shared by the two requesters and the network TX side of
// the arbiter; the master modport drives payload, the slave modport drives tready.
interface net_tx_arb_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/net_tx_arb.sv
// Two-requester AXI-Stream packet arbiter for network TX: packet-granular
// round-robin, one IDLE arbitration bubble per packet, zero-latency beats.
module net_tx_arb #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 16
) (
  input  logic               axis_aclk,
  input  logic               rstn,
  net_tx_arb_if.slave        s0,
  net_tx_arb_if.slave        s1,
  net_tx_arb_if.master       m,
  input  logic [1:0]         port_en,
  output logic               grant,
  output logic               busy,
  output logic [31:0]        pkt_cnt0,
  output logic [31:0]        pkt_cnt1
);

  // Handshake: a beat moves on an edge where tvalid and tready are both high;
  // tvalid never waits on tready, and payload holds while tvalid=1, tready=0.
  typedef enum logic {IDLE, XFER} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        rr_q, rr_d;
  logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [31:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [1:0]  rst_sync_q;
  logic        arst;
  logic [1:0]  req;
  logic        winner;
  logic        src_valid;
  logic        last_fire;

  logic [DATA_W-1:0] data_mux;
  logic [KEEP_W-1:0] keep_mux;
  logic [USER_W-1:0] user_mux;

  // Assertion reaches every flop at once; release waits two clean edges.
  always_ff @(posedge axis_aclk or posedge rstn) begin
    if (rstn) rst_sync_q <= 2'b11;
    else      rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign arst = rst_sync_q[1];

  assign req    = {s1.tvalid & port_en[1], s0.tvalid & port_en[0]};
  assign winner = (req == 2'b11) ? rr_q : req[1];

  assign data_mux = grant_q ? s1.tdata : s0.tdata;
  assign keep_mux = grant_q ? s1.tkeep : s0.tkeep;
  assign user_mux = grant_q ? s1.tuser : s0.tuser;
  assign m.tdata  = data_mux;
  assign m.tkeep  = keep_mux;
  assign m.tuser  = user_mux;
  assign m.tlast  = grant_q ? s1.tlast : s0.tlast;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    src_valid = 1'b0;
    last_fire = 1'b0;
    m.tvalid  = 1'b0;
    s0.tready = 1'b0;
    s1.tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = XFER;
          grant_d = winner;
        end
      end
      XFER: begin
        // Enables are ignored here so a started packet always completes.
        src_valid = grant_q ? s1.tvalid : s0.tvalid;
        m.tvalid  = src_valid;
        if (grant_q) s1.tready = m.tready;
        else         s0.tready = m.tready;
        last_fire = src_valid & m.tready & m.tlast;
        if (last_fire) begin
          state_d = IDLE;
          rr_d    = ~grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (last_fire) begin
      if (grant_q) pkt_cnt1_d = pkt_cnt1_q + 32'd1;
      else         pkt_cnt0_d = pkt_cnt0_q + 32'd1;
    end
  end

  always_ff @(posedge axis_aclk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      pkt_cnt0_q <= 32'd0;
      pkt_cnt1_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == XFER);
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule

// File: tb/tb_net_tx_arb.sv
// Bench for net_tx_arb: per-source packet queues drive the inputs, a
// packet-level round-robin model predicts the tagged output beat stream.
module tb_net_tx_arb;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 8;
  localparam int BW = DW + KW + UW + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  port_en;
  logic        grant;
  logic        busy;
  logic [31:0] pkt_cnt0;
  logic [31:0] pkt_cnt1;

  always #5 clk = ~clk;

  net_tx_arb_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) s0_if ();
  net_tx_arb_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) s1_if ();
  net_tx_arb_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) m_if ();

  net_tx_arb #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) dut (
    .axis_aclk (clk),
    .rstn      (rst),
    .s0        (s0_if),
    .s1        (s1_if),
    .m         (m_if),
    .port_en   (port_en),
    .grant     (grant),
    .busy      (busy),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1)
  );

  // beat = {tlast, tuser, tkeep, tdata}; expected entries carry the source tag on top
  logic [BW-1:0] src0_q[$];
  logic [BW-1:0] src1_q[$];
  logic [BW-1:0] mdl0[$];
  logic [BW-1:0] mdl1[$];
  logic [BW:0]   exp_q[$];
  logic          mdl_rr;
  logic [31:0]   mdl_cnt[2];

  int   total = 0;
  int   bad   = 0;
  logic bp_mode  = 1'b0;
  logic bp_phase = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) begin
      logic [BW-1:0] bt;
      bt = {(b == len - 1), UW'($urandom), KW'($urandom), DW'($urandom)};
      if (src == 0) begin src0_q.push_back(bt); mdl0.push_back(bt); end
      else          begin src1_q.push_back(bt); mdl1.push_back(bt); end
    end
  endtask

  // Whole packets, round-robin between enabled sources that still hold packets.
  task automatic predict(input logic [1:0] en);
    logic r0, r1, w;
    logic [BW-1:0] bt;
    while (1) begin
      r0 = en[0] && (mdl0.size() > 0);
      r1 = en[1] && (mdl1.size() > 0);
      if (!r0 && !r1) break;
      w = (r0 && r1) ? mdl_rr : r1;
      do begin
        bt = w ? mdl1.pop_front() : mdl0.pop_front();
        exp_q.push_back({w, bt});
      end while (!bt[BW-1]);
      mdl_rr     = !w;
      mdl_cnt[w] = mdl_cnt[w] + 32'd1;
    end
  endtask

  task automatic model_reset();
    src0_q.delete(); src1_q.delete();
    mdl0.delete();   mdl1.delete();
    exp_q.delete();
    mdl_rr     = 1'b0;
    mdl_cnt[0] = 32'd0;
    mdl_cnt[1] = 32'd0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  task automatic drive_src(input int idx);
    logic acc;
    forever begin
      @(negedge clk);
      acc = (idx == 1) ? (s1_if.tvalid && s1_if.tready) : (s0_if.tvalid && s0_if.tready);
      @(posedge clk);
      #1;
      if (idx == 0) begin
        if (acc && src0_q.size() > 0) void'(src0_q.pop_front());
        s0_if.tvalid = (src0_q.size() > 0);
        if (src0_q.size() > 0) {s0_if.tlast, s0_if.tuser, s0_if.tkeep, s0_if.tdata} = src0_q[0];
      end else begin
        if (acc && src1_q.size() > 0) void'(src1_q.pop_front());
        s1_if.tvalid = (src1_q.size() > 0);
        if (src1_q.size() > 0) {s1_if.tlast, s1_if.tuser, s1_if.tkeep, s1_if.tdata} = src1_q[0];
      end
    end
  endtask

  initial begin
    s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tuser = '0;
    drive_src(0);
  end

  initial begin
    s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0; s1_if.tdata = '0; s1_if.tkeep = '0; s1_if.tuser = '0;
    drive_src(1);
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard and protocol checks, sampled mid-cycle.
  initial begin
    logic [BW-1:0] cur;
    logic [BW-1:0] held;
    logic          stall_prev;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        cur = {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
        if (stall_prev) chk("stall_stable", {18'd0, m_if.tvalid, cur}, {18'd0, 1'b1, held});
        if (bp_phase) chk("bp_s0_tready", 64'(s0_if.tready), 64'd0);
        if (busy) begin
          chk("other_tready", 64'(grant ? s0_if.tready : s1_if.tready), 64'd0);
        end else begin
          chk("idle_bubble", {61'd0, m_if.tvalid, s0_if.tready, s1_if.tready}, 64'd0);
        end
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) chk("extra_beat", 64'd0, 64'd1);
          else chk("beat", {18'd0, grant, cur}, {18'd0, exp_q.pop_front()});
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        held       = cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0, n1;
    port_en = 2'b11;
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", {58'd0, m_if.tvalid, s0_if.tready, s1_if.tready, busy, grant, 1'b0}, 64'd0);
    chk("rst_cnt", {pkt_cnt1, pkt_cnt0}, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single requester: latency, bubble, 4 beats, counters.
    push_pkt(0, 4);
    predict(2'b11);
    n = 0;
    do begin @(negedge clk); n++; end while (!s0_if.tvalid && n < 20);
    chk("single_s0_valid_seen", 64'(s0_if.tvalid), 64'd1);
    chk("single_arb_mvalid", 64'(m_if.tvalid), 64'd0);
    chk("single_arb_s0_tready", 64'(s0_if.tready), 64'd0);
    @(negedge clk);
    chk("single_mvalid_rise", 64'(m_if.tvalid), 64'd1);
    wait_done("single", 100);
    chk("single_cnt0", 64'(pkt_cnt0), 64'(mdl_cnt[0]));
    chk("single_cnt1", 64'(pkt_cnt1), 64'(mdl_cnt[1]));
    chk("single_busy_low", 64'(busy), 64'd0);

    // Contention: six 3-beat packets alternate.
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 3);
      push_pkt(1, 3);
    end
    predict(2'b11);
    wait_done("contention", 300);
    chk("cont_cnt0", 64'(pkt_cnt0), 64'(mdl_cnt[0]));
    chk("cont_cnt1", 64'(pkt_cnt1), 64'(mdl_cnt[1]));

    // Backpressure on a 5-beat s1 packet.
    @(negedge clk);
    bp_mode  = 1'b1;
    bp_phase = 1'b1;
    push_pkt(1, 5);
    predict(2'b11);
    wait_done("backpressure", 300);
    bp_phase = 1'b0;
    chk("bp_cnt1", 64'(pkt_cnt1), 64'(mdl_cnt[1]));

    // Random mixes, including one-beat packets, under random backpressure.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      bp_mode = 1'($urandom_range(0, 1));
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int p = 0; p < n0; p++) push_pkt(0, $urandom_range(1, 5));
      for (int p = 0; p < n1; p++) push_pkt(1, $urandom_range(1, 5));
      predict(2'b11);
      wait_done("random_mix", 1000);
      chk("rand_cnt0", 64'(pkt_cnt0), 64'(mdl_cnt[0]));
      chk("rand_cnt1", 64'(pkt_cnt1), 64'(mdl_cnt[1]));
    end
    bp_mode = 1'b0;

    // Enable gating: only s1 served; dropping its enable mid-packet is harmless.
    @(negedge clk);
    port_en = 2'b10;
    push_pkt(0, 2);
    push_pkt(1, 6);
    predict(2'b10);
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && grant) && n < 20);
    chk("gate_s1_granted", {62'd0, busy, grant}, 64'd3);
    @(negedge clk);
    port_en = 2'b00;
    wait_done("gate", 200);
    repeat (10) @(negedge clk);
    chk("gate_s0_pending", 64'(s0_if.tvalid), 64'd1);
    chk("gate_not_busy", 64'(busy), 64'd0);
    chk("gate_cnt0", 64'(pkt_cnt0), 64'(mdl_cnt[0]));
    chk("gate_cnt1", 64'(pkt_cnt1), 64'(mdl_cnt[1]));
    port_en = 2'b11;
    predict(2'b11);
    wait_done("gate_drain", 200);
    chk("gate_drain_cnt0", 64'(pkt_cnt0), 64'(mdl_cnt[0]));

    // Counter wrap from an all-ones preload.
    @(negedge clk);
    force dut.pkt_cnt0_q = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt0_q;
    mdl_cnt[0] = 32'hFFFF_FFFF;
    chk("wrap_preload", 64'(pkt_cnt0), 64'(mdl_cnt[0]));
    push_pkt(0, 2);
    predict(2'b11);
    wait_done("wrap", 100);
    chk("wrap_cnt0", 64'(pkt_cnt0), 64'(mdl_cnt[0]));

    // Reset in the middle of an s0 packet.
    @(negedge clk);
    push_pkt(0, 8);
    predict(2'b11);
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 20);
    chk("midrst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_outputs", {58'd0, m_if.tvalid, s0_if.tready, s1_if.tready, busy, grant, 1'b0}, 64'd0);
    chk("midrst_cnt", {pkt_cnt1, pkt_cnt0}, 64'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", {62'd0, busy, m_if.tvalid}, 64'd0);

    // Arbitration restarts with requester 0 first.
    push_pkt(0, 2);
    push_pkt(1, 2);
    predict(2'b11);
    wait_done("post_rst", 200);
    chk("post_rst_cnt0", 64'(pkt_cnt0), 64'(mdl_cnt[0]));
    chk("post_rst_cnt1", 64'(pkt_cnt1), 64'(mdl_cnt[1]));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
